axi_rd_arb_bridge: RTL

- Parametrised successor to the single-port SRAM/cache-to-AXI read path.
- Multiplexes NUM_CLIENTS cache-refill / uncached read clients onto one AXI3 AR/R channel pair.
- Uses round-robin arbitration, per-client outstanding-transaction limits and registered data return steered by RID.
- Sits between the icache/dcache/uncached-load ports and the top-level AXI crossbar; the write path is a separate block.

---
 rtl/axi_bridge_pkg.sv | 26 ++
 rtl/axi_rd_arb_bridge_if.sv | 41 ++++
 rtl/rr_arbiter.sv | 23 ++
 rtl/axi_rd_arb_bridge.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_bridge_pkg.sv
// Shared constants and AR state encoding for the AXI3 read arbitration bridge.
package axi_bridge_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  localparam int unsigned LINE_OFF_W  = 4;
  localparam int unsigned CLI_LEN_W   = 8;
  localparam int unsigned CLI_SIZE_W  = 3;
  localparam int unsigned AXI_LEN_W   = 4;
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_LOCK_W  = 2;
  localparam int unsigned AXI_CACHE_W = 4;
  localparam int unsigned AXI_PROT_W  = 3;
  localparam int unsigned AXI_RESP_W  = 2;
  // Per-client outstanding counter; MAX_OUTST is limited to 1..3.
  localparam int unsigned OUTST_W     = 2;

  typedef enum logic [1:0] {
    AR_IDLE = 2'b01,
    AR_SEND = 2'b10
  } ar_state_e;

endpackage

// File: rtl/axi_rd_arb_bridge_if.sv
// AXI3 AR/R channel pair; master = bridge side, slave = crossbar side.
interface axi_rd_arb_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
);
  import axi_bridge_pkg::*;

  logic [ID_W-1:0]        arid;
  logic [ADDR_W-1:0]      araddr;
  logic [AXI_LEN_W-1:0]   arlen;
  logic [AXI_SIZE_W-1:0]  arsize;
  logic [AXI_BURST_W-1:0] arburst;
  logic [AXI_LOCK_W-1:0]  arlock;
  logic [AXI_CACHE_W-1:0] arcache;
  logic [AXI_PROT_W-1:0]  arprot;
  logic                   arvalid;
  logic                   arready;

  logic [ID_W-1:0]        rid;
  logic [DATA_W-1:0]      rdata;
  logic [AXI_RESP_W-1:0]  rresp;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Cyclic priority arbiter: first requester at or after ptr wins, one-hot grant.
module rr_arbiter #(
  parameter  int unsigned N     = 3,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt_c,
  output logic             valid_c
);

  always_comb begin
    gnt_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      logic [PTR_W-1:0] idx;
      idx = PTR_W'((32'(ptr) + k) % N);
      if ((gnt_c == '0) && req[idx]) gnt_c[idx] = 1'b1;
    end
  end

  assign valid_c = |req;

endmodule

// File: rtl/axi_rd_arb_bridge.sv
// Round-robin multiplexer of NUM_CLIENTS read clients onto one AXI3 AR/R pair.
// Define BRIDGE_RAW_CHECK_EN to hold clients whose line matches a pending write.
module axi_rd_arb_bridge
  import axi_bridge_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 3,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ID_W        = 4,
  parameter int unsigned MAX_OUTST   = 2
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NUM_CLIENTS-1:0]            cli_rd_req,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]     cli_rd_addr,
  input  logic [NUM_CLIENTS*CLI_LEN_W-1:0]  cli_rd_len,
  input  logic [NUM_CLIENTS*CLI_SIZE_W-1:0] cli_rd_size,
  output logic [NUM_CLIENTS-1:0]            cli_rd_rdy,
  output logic [NUM_CLIENTS-1:0]            cli_ret_valid,
  output logic [NUM_CLIENTS-1:0]            cli_ret_last,
  output logic [DATA_W-1:0]                 cli_ret_data,
  output logic                              rd_err,
  input  logic                              wr_busy,
  input  logic [ADDR_W-1:0]                 wr_addr,
  axi_rd_arb_bridge_if.master               axi
);

  localparam int unsigned PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  logic [NUM_CLIENTS-1:0][ADDR_W-1:0]     cli_addr_a;
  logic [NUM_CLIENTS-1:0][CLI_LEN_W-1:0]  cli_len_a;
  logic [NUM_CLIENTS-1:0][CLI_SIZE_W-1:0] cli_size_a;

  assign cli_addr_a = cli_rd_addr;
  assign cli_len_a  = cli_rd_len;
  assign cli_size_a = cli_rd_size;

  ar_state_e                          state_q, state_d;
  logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]                    arid_q, arid_d;
  logic [ADDR_W-1:0]                  araddr_q, araddr_d;
  logic [AXI_LEN_W-1:0]               arlen_q, arlen_d;
  logic [AXI_SIZE_W-1:0]              arsize_q, arsize_d;
  logic                               arvalid_q, arvalid_d;
  logic [NUM_CLIENTS-1:0]             cli_rd_rdy_q, cli_rd_rdy_d;
  logic [NUM_CLIENTS-1:0]             ret_valid_q, ret_valid_d;
  logic [NUM_CLIENTS-1:0]             ret_last_q, ret_last_d;
  logic [DATA_W-1:0]                  ret_data_q, ret_data_d;
  logic                               rd_err_q, rd_err_d;
  logic                               rready_q, rready_d;
  logic [NUM_CLIENTS-1:0][OUTST_W-1:0] outst_q, outst_d;

  logic [NUM_CLIENTS-1:0] raw_blk_c;
  logic [NUM_CLIENTS-1:0] elig_c;
  logic [NUM_CLIENTS-1:0] gnt_c;
  logic                   gnt_valid_c;
  logic [PTR_W-1:0]       gnt_idx_c;
  logic                   grant_c;
  logic                   ar_hs_c;
  logic                   r_hs_c;
  logic                   rid_ok_c;
  logic                   unused_c;

`ifdef BRIDGE_RAW_CHECK_EN
  // A read may not overtake a write to the same 16-byte line.
  always_comb begin
    raw_blk_c = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      raw_blk_c[i] = wr_busy &&
        (cli_addr_a[i][ADDR_W-1:LINE_OFF_W] == wr_addr[ADDR_W-1:LINE_OFF_W]);
    end
  end
`else
  assign raw_blk_c = '0;
`endif

  // Only the low AXI3 length bits are forwarded; write-side inputs may be ignored.
  assign unused_c = ^{cli_len_a, wr_busy, wr_addr};

  always_comb begin
    elig_c = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      elig_c[i] = cli_rd_req[i] && (outst_q[i] < OUTST_W'(MAX_OUTST)) && !raw_blk_c[i];
    end
  end

  rr_arbiter #(.N(NUM_CLIENTS)) u_rr_arbiter (
    .req     (elig_c),
    .ptr     (rr_ptr_q),
    .gnt_c   (gnt_c),
    .valid_c (gnt_valid_c)
  );

  always_comb begin
    gnt_idx_c = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (gnt_c[i]) gnt_idx_c = PTR_W'(i);
    end
  end

  assign grant_c  = (state_q == AR_IDLE) && gnt_valid_c;
  assign ar_hs_c  = arvalid_q && axi.arready;
  assign r_hs_c   = axi.rvalid && rready_q;
  assign rid_ok_c = 32'(axi.rid) < NUM_CLIENTS;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= AR_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      AR_IDLE: if (gnt_valid_c) state_d = AR_SEND;
      AR_SEND: if (axi.arready) state_d = AR_IDLE;
      default: state_d = AR_IDLE;
    endcase
  end

  // AR capture on grant; fields hold until the handshake.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    arid_d       = arid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arvalid_d    = arvalid_q;
    cli_rd_rdy_d = '0;
    if (grant_c) begin
      arid_d       = ID_W'(gnt_idx_c);
      araddr_d     = cli_addr_a[gnt_idx_c];
      arlen_d      = cli_len_a[gnt_idx_c][AXI_LEN_W-1:0];
      arsize_d     = cli_size_a[gnt_idx_c];
      arvalid_d    = 1'b1;
      cli_rd_rdy_d = gnt_c;
      rr_ptr_d     = (gnt_idx_c == PTR_W'(NUM_CLIENTS - 1)) ? '0 : gnt_idx_c + PTR_W'(1);
    end else if (ar_hs_c) begin
      arvalid_d = 1'b0;
    end
  end

  // R steering by RID plus per-client outstanding bookkeeping.
  always_comb begin
    rready_d    = 1'b1;
    ret_valid_d = '0;
    ret_last_d  = '0;
    ret_data_d  = ret_data_q;
    rd_err_d    = rd_err_q;
    outst_d     = outst_q;
    if (r_hs_c) begin
      if (rid_ok_c) ret_data_d = axi.rdata;
      if (!rid_ok_c || (axi.rresp != RESP_OKAY)) rd_err_d = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      logic inc;
      logic dec;
      inc = ar_hs_c && (arid_q == ID_W'(i));
      dec = r_hs_c && axi.rlast && (axi.rid == ID_W'(i));
      if (r_hs_c && (axi.rid == ID_W'(i))) begin
        ret_valid_d[i] = 1'b1;
        ret_last_d[i]  = axi.rlast;
      end
      if (inc && !dec)      outst_d[i] = outst_q[i] + OUTST_W'(1);
      else if (dec && !inc) outst_d[i] = outst_q[i] - OUTST_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_ptr_q     <= '0;
      arid_q       <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= SIZE_WORD;
      arvalid_q    <= 1'b0;
      cli_rd_rdy_q <= '0;
      ret_valid_q  <= '0;
      ret_last_q   <= '0;
      ret_data_q   <= '0;
      rd_err_q     <= 1'b0;
      rready_q     <= 1'b0;
      outst_q      <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      arid_q       <= arid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arvalid_q    <= arvalid_d;
      cli_rd_rdy_q <= cli_rd_rdy_d;
      ret_valid_q  <= ret_valid_d;
      ret_last_q   <= ret_last_d;
      ret_data_q   <= ret_data_d;
      rd_err_q     <= rd_err_d;
      rready_q     <= rready_d;
      outst_q      <= outst_d;
    end
  end

  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = '0;
  assign axi.arcache = '0;
  assign axi.arprot  = '0;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign cli_rd_rdy    = cli_rd_rdy_q;
  assign cli_ret_valid = ret_valid_q;
  assign cli_ret_last  = ret_last_q;
  assign cli_ret_data  = ret_data_q;
  assign rd_err        = rd_err_q;

endmodule
